cache_mem_subsystem: RTL and testbench
======================================

# cache_mem_subsystem

Memory-side block of the cache processor. Contains two block-fill state machines, one per cache (I and D), and a shared arbiter fronting a single multicycle 16-bit word memory. On a miss it fetches an aligned 16-byte block as eight sequential 2-byte words, with data-cache traffic taking priority. It also performs single-word data-cache write-through.

## Interface

Parameters:
- ADDR_W, 16: byte address width
- DATA_W, 16: word width
- MEM_LATENCY, 4: cycles from request-present to data-valid
- WORDS_PER_BLOCK, 8: words per cache block

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- miss_detected_I / miss_detected_D  in  1  tag-match logic reports a miss
- miss_address_I / miss_address_D  in  16  byte address that missed
- d_write  in  1  D-side write request; held high until write_ack
- d_write_addr  in  16  write byte address
- d_data  in  16  write data
- fsm_busy_I / fsm_busy_D  out  1  fill in progress (pipeline stall)
- write_data_array_I / write_data_array_D  out  1  data-array write enable for the current word
- write_tag_array_I / write_tag_array_D  out  1  tag write; high only on the final word
- memory_address_I / memory_address_D  out  16  byte address of the word being delivered
- memory_data_out_I / memory_data_out_D  out  16  fill data, a copy of the shared memory data
- write_ack  out  1  one-cycle pulse when a D write completes

## Operation

**Fill FSM (one per side)**
- States are IDLE and WAIT.
- A 3-bit word counter `cnt` is held in a register.
- `base = {miss_address[15:4], 4'b0}`.

**IDLE**
- fsm_busy = miss_detected, combinationally, in the same cycle.
- The request address is base + 0.
- On miss_detected: go to WAIT with cnt = 0.

**WAIT**
- fsm_busy = 1, except in the final-word valid cycle, where it is 0.
- On mem_valid:
  - write_data_array = 1.
  - write_tag_array = 1 when cnt == 7.
  - cnt increments.
  - If cnt == 7, return to IDLE.
- memory_address = base + 2·cnt for the word being delivered.
- Request address presented to the arbiter = base + 2·(cnt + mem_valid). The next word is therefore requested in the same cycle the current word lands.
- miss_detected is ignored outside IDLE.

**Arbiter/memory**
- Memory is 32K × 16, word index = addr[15:1]. Contents are not reset.
- The arbiter is idle, or busy with owner ∈ {I, D-read, D-write}, a 2-bit age counter and a latched address.
- Accepts a new request when idle or in the cycle its current transaction completes.
- Priority is D-write, then D-read, then I. No preemption of an accepted transaction.
- Read:
  - The word at the latched address is driven on data_out in cycle c+4 (c = accept cycle).
  - The owner's mem_valid is high in that cycle only.
- Write:
  - Memory is updated at the accept edge.
  - write_ack pulses in cycle c+4.
- d_write and a D fill are never concurrent; this is the caller's responsibility.

**Reset**
- All FSMs go to IDLE, cnt = 0, arbiter idle.
- All outputs are 0 except the address outputs, which are combinational from the inputs.
- Reset mid-fill abandons the fill. A write already accepted remains in memory.

## Timing

- Uncontended fill:
  - Miss in cycle 0.
  - Word k is valid in cycle 4(k+1).
  - Final word in cycle 32, with fsm_busy low and write_tag_array high in that cycle.
- fsm_busy is high in cycles 0–31.
- Contention: a losing side keeps fsm_busy high with the request held. It is granted in the winner's completion cycle.
- Simultaneous I and D miss in cycle 0: D completes in cycle 32; I words are valid in cycles 36, 40, …, 64.
- Outputs to caches are combinational from state plus the arbiter valid. No extra register stage.

## Structure

- Shared package `cache_mem_pkg`:
  - ADDR_W, DATA_W, MEM_LATENCY, WORDS_PER_BLOCK
  - Fill-FSM state enum {IDLE, WAIT}
  - Arbiter owner enum
- Sub-module `cache_fill_fsm`, instantiated twice.
- Arbiter, age counter and memory array are inline in the top.

## Test plan

- **Idle:** after reset, no misses for 2 cycles → all write_data_array/write_tag_array/fsm_busy = 0.
- **I miss:**
  - Stimulus: miss_address_I = 0x000F in cycle 0, mem[0..7] preloaded with 0xA000+i.
  - fsm_busy_I = 1 at +1 ns.
  - Cycle 4: write_data_array_I = 1, memory_address_I = 0x0000, data 0xA000.
  - Cycle 32: fsm_busy_I = 0, write_data_array_I = write_tag_array_I = 1, address 0x000E, data 0xA007.
  - D outputs stay 0 throughout.
- **Concurrent misses:**
  - Stimulus: I miss at 0x0100 and D miss at 0x0200 in cycle 0.
  - D valids in cycles 4..32.
  - I valids in cycles 36..64; fsm_busy_I high through cycle 63.
- **Write then fill:**
  - Stimulus: d_write at 0x0204 with data 0x1234.
  - write_ack in cycle 4.
  - A subsequent D miss at 0x0200 delivers word 2 = 0x1234.
- **Write blocks I:** d_write and I miss in the same cycle → write accepted first; I first valid in cycle 8.
- **Reset mid-fill:** rst_n low in cycle 10 of an I fill → all outputs 0. A new miss afterwards restarts at word 0.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared constants and types for the cache memory subsystem.
// Holds the memory geometry, the fill-FSM state encoding and the
// arbiter owner encoding used by cache_fill_fsm and cache_mem_subsystem.
package cache_mem_pkg;

    localparam int ADDR_W          = 16;
    localparam int DATA_W          = 16;
    localparam int MEM_LATENCY     = 4;
    localparam int WORDS_PER_BLOCK = 8;

    localparam int BYTES_PER_WORD = DATA_W / 8;
    localparam int WORD_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam int BLOCK_BYTES    = WORDS_PER_BLOCK * BYTES_PER_WORD;
    localparam int CNT_W          = $clog2(WORDS_PER_BLOCK);
    localparam int AGE_W          = 2;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILL_WAIT = 1'b1
    } fill_state_t;

    typedef enum logic [1:0] {
        OWN_I   = 2'd0,
        OWN_DRD = 2'd1,
        OWN_DWR = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/cache_fill_fsm.sv
// Block-fill controller for one cache side.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   miss_detected       miss reported by tag-match logic
//   miss_address        byte address that missed (held stable during the fill)
//   mem_valid           arbiter says this side's word is on the memory data bus
//   fsm_busy            pipeline stall
//   write_data_array    data-array write enable for the delivered word
//   write_tag_array     tag write, final word only
//   memory_address      byte address of the word being delivered
//   mem_req/mem_req_addr  request to the arbiter
//
// state     | meaning
// FILL_IDLE | no fill; a miss starts one and requests word 0
// FILL_WAIT | waiting for word cnt; next word requested as the current lands
module cache_fill_fsm
    import cache_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              mem_valid,
    output logic              fsm_busy,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [ADDR_W-1:0] memory_address,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_req_addr
);

    fill_state_t        r_state;
    fill_state_t        w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_req_cnt;
    logic [ADDR_W-1:0]  w_base;
    logic               w_last;

    assign w_base    = miss_address & ~ADDR_W'(BLOCK_BYTES - 1);
    assign w_last    = (r_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) && mem_valid;
    assign w_req_cnt = r_cnt + CNT_W'(mem_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            FILL_IDLE: begin
                if (miss_detected) begin
                    w_state_nxt = FILL_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            FILL_WAIT: begin
                if (mem_valid) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_last) w_state_nxt = FILL_IDLE;
                end
            end
            default: w_state_nxt = FILL_IDLE;
        endcase
    end

    always_comb begin
        fsm_busy         = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        mem_req          = 1'b0;
        mem_req_addr     = w_base;
        memory_address   = w_base + (ADDR_W'(r_cnt) << WORD_SHIFT);
        case (r_state)
            FILL_IDLE: begin
                fsm_busy = miss_detected;
                mem_req  = miss_detected;
            end
            FILL_WAIT: begin
                write_data_array = mem_valid;
                write_tag_array  = w_last;
                // Stall drops in the final-word cycle so the pipeline can
                // replay the access against the freshly written line.
                fsm_busy         = !w_last;
                mem_req          = !w_last;
                mem_req_addr     = w_base + (ADDR_W'(w_req_cnt) << WORD_SHIFT);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cache_mem_subsystem.sv
// Memory side of the cache processor: I and D block-fill FSMs sharing one
// multicycle word memory through a fixed-priority arbiter, plus D-side
// single-word write-through. Sizing comes from cache_mem_pkg.
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   miss_detected_I/D, miss_address_I/D   miss reports from tag logic
//   d_write, d_write_addr, d_data         D write-through request (held to ack)
//   fsm_busy_I/D                          fill in progress
//   write_data_array_I/D, write_tag_array_I/D   array write enables
//   memory_address_I/D, memory_data_out_I/D     delivered word address/data
//   write_ack                             one-cycle write completion pulse
module cache_mem_subsystem
    import cache_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected_I,
    input  logic              miss_detected_D,
    input  logic [ADDR_W-1:0] miss_address_I,
    input  logic [ADDR_W-1:0] miss_address_D,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_write_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              fsm_busy_I,
    output logic              fsm_busy_D,
    output logic              write_data_array_I,
    output logic              write_data_array_D,
    output logic              write_tag_array_I,
    output logic              write_tag_array_D,
    output logic [ADDR_W-1:0] memory_address_I,
    output logic [ADDR_W-1:0] memory_address_D,
    output logic [DATA_W-1:0] memory_data_out_I,
    output logic [DATA_W-1:0] memory_data_out_D,
    output logic              write_ack
);

    localparam int MEM_WORDS = 2 ** (ADDR_W - 1);

    logic              r_busy;
    arb_owner_t        r_owner;
    logic [AGE_W-1:0]  r_age;
    logic [ADDR_W-2:0] r_addr;
    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    logic              w_req_I, w_req_D;
    logic [ADDR_W-1:0] w_req_addr_I, w_req_addr_D;
    logic              w_valid_I, w_valid_D;
    logic              w_done, w_can_accept, w_dwr_req, w_accept;
    arb_owner_t        w_grant;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_addr_bits;

    assign w_unused_addr_bits = ^{w_req_addr_I[0], w_req_addr_D[0], d_write_addr[0]};

    assign w_done       = r_busy && (r_age == AGE_W'(MEM_LATENCY - 1));
    assign w_can_accept = !r_busy || w_done;
    // d_write is still high in its own ack cycle; do not accept it twice.
    assign w_dwr_req    = d_write && !(w_done && r_owner == OWN_DWR);

    always_comb begin
        w_accept     = 1'b0;
        w_grant      = OWN_I;
        w_grant_addr = w_req_addr_I;
        if (w_can_accept) begin
            if (w_dwr_req) begin
                w_accept     = 1'b1;
                w_grant      = OWN_DWR;
                w_grant_addr = d_write_addr;
            end else if (w_req_D) begin
                w_accept     = 1'b1;
                w_grant      = OWN_DRD;
                w_grant_addr = w_req_addr_D;
            end else if (w_req_I) begin
                w_accept     = 1'b1;
                w_grant      = OWN_I;
                w_grant_addr = w_req_addr_I;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_owner <= OWN_I;
            r_age   <= '0;
            r_addr  <= '0;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_owner <= w_grant;
            r_age   <= '0;
            r_addr  <= w_grant_addr[ADDR_W-1:1];
        end else if (w_done) begin
            r_busy  <= 1'b0;
        end else if (r_busy) begin
            r_age   <= r_age + AGE_W'(1);
        end
    end

    // Contents survive reset; writes land at the accept edge.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept && (w_grant == OWN_DWR))
            r_mem[d_write_addr[ADDR_W-1:1]] <= d_data;
    end

    assign w_rd_data = (w_done && r_owner != OWN_DWR) ? r_mem[r_addr] : '0;
    assign w_valid_I = w_done && (r_owner == OWN_I);
    assign w_valid_D = w_done && (r_owner == OWN_DRD);
    assign write_ack = w_done && (r_owner == OWN_DWR);

    assign memory_data_out_I = w_rd_data;
    assign memory_data_out_D = w_rd_data;

    cache_fill_fsm u_fill_i (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected_I),
        .miss_address     (miss_address_I),
        .mem_valid        (w_valid_I),
        .fsm_busy         (fsm_busy_I),
        .write_data_array (write_data_array_I),
        .write_tag_array  (write_tag_array_I),
        .memory_address   (memory_address_I),
        .mem_req          (w_req_I),
        .mem_req_addr     (w_req_addr_I)
    );

    cache_fill_fsm u_fill_d (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected_D),
        .miss_address     (miss_address_D),
        .mem_valid        (w_valid_D),
        .fsm_busy         (fsm_busy_D),
        .write_data_array (write_data_array_D),
        .write_tag_array  (write_tag_array_D),
        .memory_address   (memory_address_D),
        .mem_req          (w_req_D),
        .mem_req_addr     (w_req_addr_D)
    );

endmodule

// File: tb/tb_cache_mem_subsystem.sv
// Self-checking bench for cache_mem_subsystem. Expected timing comes from
// the block's cycle rules (accept edge + 4, D before I, writes first), and
// expected data from a word-indexed model memory updated on every write.
module tb_cache_mem_subsystem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected_I, miss_detected_D;
    logic [15:0] miss_address_I, miss_address_D;
    logic        d_write;
    logic [15:0] d_write_addr, d_data;
    logic        fsm_busy_I, fsm_busy_D;
    logic        write_data_array_I, write_data_array_D;
    logic        write_tag_array_I, write_tag_array_D;
    logic [15:0] memory_address_I, memory_address_D;
    logic [15:0] memory_data_out_I, memory_data_out_D;
    logic        write_ack;

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl [int];

    always #5 clk = ~clk;

    cache_mem_subsystem dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .miss_detected_I    (miss_detected_I),
        .miss_detected_D    (miss_detected_D),
        .miss_address_I     (miss_address_I),
        .miss_address_D     (miss_address_D),
        .d_write            (d_write),
        .d_write_addr       (d_write_addr),
        .d_data             (d_data),
        .fsm_busy_I         (fsm_busy_I),
        .fsm_busy_D         (fsm_busy_D),
        .write_data_array_I (write_data_array_I),
        .write_data_array_D (write_data_array_D),
        .write_tag_array_I  (write_tag_array_I),
        .write_tag_array_D  (write_tag_array_D),
        .memory_address_I   (memory_address_I),
        .memory_address_D   (memory_address_D),
        .memory_data_out_I  (memory_data_out_I),
        .memory_data_out_D  (memory_data_out_D),
        .write_ack          (write_ack)
    );

    task automatic chk1(input string tag, input int cyc, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A side whose first word is granted at cycle st delivers word k at
    // st+4(k+1) and stalls from the miss cycle through st+31.
    task automatic check_side(input string s, input bit en, input logic [15:0] base,
                              input int st, input int cyc, input logic busy,
                              input logic wda, input logic wta,
                              input logic [15:0] addr, input logic [15:0] data);
        bit v;
        int k;
        v = en && (cyc >= st + 4) && (cyc <= st + 32) && ((cyc - st) % 4 == 0);
        k = v ? (cyc - st) / 4 - 1 : 0;
        chk1({s, "_busy"}, cyc, busy, en && (cyc <= st + 31));
        chk1({s, "_wr_data"}, cyc, wda, v);
        chk1({s, "_wr_tag"}, cyc, wta, v && (k == 7));
        if (v) begin
            chk16({s, "_addr"}, cyc, addr, base + 16'(2 * k));
            chk16({s, "_data"}, cyc, data, mdl[int'(base[15:1]) + k]);
        end
    endtask

    task automatic check_reset_outputs(input int cyc);
        chk1("rst_busy_I", cyc, fsm_busy_I, 1'b0);
        chk1("rst_busy_D", cyc, fsm_busy_D, 1'b0);
        chk1("rst_wda_I", cyc, write_data_array_I, 1'b0);
        chk1("rst_wda_D", cyc, write_data_array_D, 1'b0);
        chk1("rst_wta_I", cyc, write_tag_array_I, 1'b0);
        chk1("rst_wta_D", cyc, write_tag_array_D, 1'b0);
        chk16("rst_data_I", cyc, memory_data_out_I, 16'h0000);
        chk16("rst_data_D", cyc, memory_data_out_D, 16'h0000);
        chk1("rst_ack", cyc, write_ack, 1'b0);
    endtask

    // One directed step: optional write, optional I miss, optional D miss,
    // all presented in cycle 0. abort_at >= 0 pulls reset in that cycle.
    task automatic scenario(input bit wen, input logic [15:0] waddr, input logic [15:0] wdata,
                            input bit ien, input logic [15:0] iaddr,
                            input bit den, input logic [15:0] daddr,
                            input int abort_at);
        logic [15:0] ib, db;
        int si, sd, last;
        ib = iaddr & 16'hFFF0;
        db = daddr & 16'hFFF0;
        sd = 0;
        si = (den ? 32 : 0) + (wen ? 4 : 0);
        if (wen) mdl[int'(waddr[15:1])] = wdata;
        last = wen ? 4 : 0;
        if (ien && si + 32 > last) last = si + 32;
        if (den && sd + 32 > last) last = sd + 32;
        last += 2;
        miss_address_I = iaddr;
        miss_address_D = daddr;
        d_write_addr   = waddr;
        d_data         = wdata;
        for (int cyc = 0; cyc <= last; cyc++) begin
            miss_detected_I = ien && (cyc == 0);
            miss_detected_D = den && (cyc == 0);
            d_write         = wen && (cyc <= 4);
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs(cyc);
                step();
                rst_n = 1'b1;
                return;
            end
            #1;
            check_side("I", ien, ib, si, cyc, fsm_busy_I, write_data_array_I,
                       write_tag_array_I, memory_address_I, memory_data_out_I);
            check_side("D", den, db, sd, cyc, fsm_busy_D, write_data_array_D,
                       write_tag_array_D, memory_address_D, memory_data_out_D);
            chk1("write_ack", cyc, write_ack, wen && (cyc == 4));
            step();
        end
    endtask

    task automatic preload(input logic [15:0] base, input logic [15:0] seed, input bit rnd);
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v = rnd ? 16'($urandom) : seed + 16'(i);
            scenario(1'b1, base + 16'(2 * i), v, 1'b0, 16'h0, 1'b0, 16'h0, -1);
        end
    endtask

    initial begin
        logic [15:0] bi, bd, wa;
        int mode;
        rst_n = 1'b0;
        miss_detected_I = 1'b0;
        miss_detected_D = 1'b0;
        miss_address_I  = 16'h0;
        miss_address_D  = 16'h0;
        d_write         = 1'b0;
        d_write_addr    = 16'h0;
        d_data          = 16'h0;
        step();
        step();
        check_reset_outputs(-1);
        rst_n = 1'b1;

        // idle after reset
        scenario(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, -1);

        // uncontended I miss on an unaligned address
        preload(16'h0000, 16'hA000, 1'b0);
        scenario(1'b0, 16'h0, 16'h0, 1'b1, 16'h000F, 1'b0, 16'h0, -1);

        // simultaneous I and D misses: D first, I granted at D's last word
        preload(16'h0100, 16'hB100, 1'b0);
        preload(16'h0200, 16'hC200, 1'b0);
        scenario(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 1'b1, 16'h0200, -1);

        // write-through, then fill the same block
        scenario(1'b1, 16'h0204, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, -1);
        chk16("model_word2", 0, mdl[int'(16'h0102)], 16'h1234);
        scenario(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0200, -1);

        // write and I miss in the same cycle
        preload(16'h0300, 16'hD300, 1'b0);
        scenario(1'b1, 16'h0306, 16'h5A5A, 1'b1, 16'h0300, 1'b0, 16'h0, -1);

        // reset in cycle 10 of an I fill, then restart from word 0
        scenario(1'b0, 16'h0, 16'h0, 1'b1, 16'h0100, 1'b0, 16'h0, 10);
        scenario(1'b0, 16'h0, 16'h0, 1'b1, 16'h0108, 1'b0, 16'h0, -1);

        // randomized blocks, data and traffic mix
        for (int it = 0; it < 4; it++) begin
            bi   = 16'($urandom) & 16'hFFF0;
            bd   = bi + 16'h0010;
            mode = int'($urandom_range(0, 2));
            preload(bi, 16'h0, 1'b1);
            preload(bd, 16'h0, 1'b1);
            wa = bi + 16'(2 * $urandom_range(0, 7));
            case (mode)
                0: scenario(1'b1, wa, 16'($urandom), 1'b1, bi | 16'($urandom_range(0, 15)),
                            1'b0, 16'h0, -1);
                1: scenario(1'b0, 16'h0, 16'h0, 1'b0, 16'h0,
                            1'b1, bd | 16'($urandom_range(0, 15)), -1);
                default: scenario(1'b0, 16'h0, 16'h0, 1'b1, bi | 16'($urandom_range(0, 15)),
                                  1'b1, bd | 16'($urandom_range(0, 15)), -1);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
